rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two sources: the pipeline writeback stage and a multi-cycle execution unit (mul/div).
- Holds pending multi-cycle destinations in a per-register scoreboard and stalls issue on any hazard against them.
- Sits between the writeback stage and the register file inside the processor top.
- Drives the top-level reg_writedata/reg_write_addr observation ports.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register address width (16 registers)
- FIFO_DEPTH, 2, multi-cycle result buffer entries (power of two)
- STARVE_LIMIT, 4, consecutive preempted cycles before a forced drain stall

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- issue_valid  input  1  instruction in decode requests issue
- issue_long  input  1  issuing instruction is multi-cycle
- issue_rd  input  ADDR_W  destination register
- issue_rs1  input  ADDR_W  source register 1
- issue_rs2  input  ADDR_W  source register 2
- stall  output  1  hold decode/fetch this cycle (combinational from registered state)
- wb_valid  input  1  pipeline writeback valid; no backpressure
- wb_addr  input  ADDR_W  pipeline writeback address
- wb_data  input  DATA_W  pipeline writeback data
- mc_valid  input  1  multi-cycle result valid
- mc_ready  output  1  result buffer can accept
- mc_addr  input  ADDR_W  multi-cycle result address
- mc_data  input  DATA_W  multi-cycle result data
- reg_we  output  1  register-file write enable (registered)
- reg_write_addr  output  ADDR_W  register-file write address (registered)
- reg_writedata  output  DATA_W  register-file write data (registered)

Behaviour:
- Reset (rst low, async):
  - reg_we=0, reg_write_addr=0, reg_writedata=0.
  - FIFO empty, scoreboard all 0, starve counter 0.
  - mc_ready=1, stall=0.
- Selection each edge:
  - wb_valid=1 → output register loads wb_addr/wb_data with reg_we=1.
  - Else FIFO non-empty → output loads FIFO head with reg_we=1; head is popped.
  - Else reg_we=0 and reg_write_addr/reg_writedata hold their previous values.
- Latency:
  - wb to reg_we: 1 cycle.
  - mc accepted at edge N: earliest reg_we high after edge N+1 (2 cycles).
- mc handshake:
  - Transfer when mc_valid && mc_ready.
  - mc_ready = !full, where full is evaluated before the same-edge pop. No push-through on full.
  - mc_data/mc_addr are stable while mc_valid && !mc_ready.
  - Simultaneous push and pop on a non-full FIFO is legal; count is unchanged.
- FIFO: circular, FIFO_DEPTH entries, order preserved. Pointers wrap modulo FIFO_DEPTH. Count is ADDR-independent, width clog2(FIFO_DEPTH)+1.
- Scoreboard, pending[16]:
  - Set pending[issue_rd] when issue_valid && issue_long && !stall.
  - Clear pending[addr] on FIFO pop.
  - Same-edge set and clear of the same register: set wins.
- stall = issue_valid && (pending[issue_rs1] || pending[issue_rs2] || pending[issue_rd]) || full || starve.
  - The pending[issue_rd] term blocks WAW for both short and long ops.
- Starvation:
  - Counter increments each edge where FIFO is non-empty and wb_valid=1.
  - Counter resets to 0 on pop or when FIFO is empty.
  - starve = (counter >= STARVE_LIMIT); held until pop.
  - Stall lets the pipeline drain, so wb_valid eventually drops.
- Counter saturates at STARVE_LIMIT.
- Reset mid-operation: buffered results and pending bits are discarded. Upstream flushes in-flight mc ops on the same reset.

Decomposition:
- Shared package rf_pkg: DATA_W, ADDR_W, NUM_REGS=16, and a typedef for the write struct {addr, data}.
- One sub-module: rf_result_fifo, a parameterised synchronous FIFO with valid/ready push, pop, full, empty, and a head output.
- Scoreboard, selection and starvation logic stay in rf_write_arbiter.

Test Plan:
- Reset: hold rst=0 with all inputs toggling → reg_we=0, stall=0, mc_ready=1, reg_writedata=0.
- Writeback pass-through: wb_valid with addr 3, data 0xDEADBEEF → next cycle reg_we=1, reg_write_addr=3, reg_writedata=0xDEADBEEF.
- Long-op hazard:
  - Issue long op with rd=5 → pending[5]=1.
  - Issue with rs1=5 → stall=1.
  - mc result addr 5, data 0x12345678 arrives with wb idle → written 2 cycles later; stall drops the cycle after the pop.
- Contention:
  - wb_valid held high while two mc results arrive (addr 6 then 7) → mc_ready=0 after the second, stall=1 (full).
  - Drop wb_valid → addr 6 written, then addr 7, in order.
- Starvation: one buffered result with wb_valid held high → stall asserts after 4 preempted cycles; stays until wb_valid drops and the pop occurs.
- Async reset mid-operation: assert rst between edges with FIFO holding 2 entries and pending[9]=1 → outputs clear immediately, FIFO empty, pending cleared, no write to addr 9 afterwards.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file widths and the write record carried from a result
// source to the register-file write port.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_result_fifo.sv
// Circular result buffer for multi-cycle unit results. Push is a
// valid/ready handshake; pop is a plain request honoured only when non-empty.
module rf_result_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Full is judged on registered occupancy, so a same-edge pop never frees a slot.
  assign full_o       = (count_q == CNT_FULL);
  assign empty_o      = (count_q == '0);
  assign push_ready_o = !full_o;
  assign do_push      = push_valid_i && !full_o;
  assign do_pop       = pop_i && !empty_o;
  assign head_o       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// and buffered multi-cycle results, and stalls issue on hazards against them.
module rf_write_arbiter #(
  parameter int DATA_W       = rf_pkg::DATA_W,
  parameter int ADDR_W       = rf_pkg::ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_long,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] mc_addr,
  input  logic [DATA_W-1:0] mc_data,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_write_addr,
  output logic [DATA_W-1:0] reg_writedata
);

  localparam int NREGS   = 1 << ADDR_W;
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_LIMIT);

  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;

  logic               reg_we_q, reg_we_d;
  logic [ADDR_W-1:0]  reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]  reg_data_q, reg_data_d;

  logic [NREGS-1:0]   pending_q, pending_d;
  logic [SC_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic               starve;
  logic               hazard;
  logic               issue_fire;

  // mc_valid/mc_ready: a result transfers on an edge where both are high.
  // Ready depends only on registered occupancy, and the producer holds
  // mc_addr/mc_data unchanged while valid is high and ready is low.
  rf_result_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (rst),
    .push_valid_i (mc_valid),
    .push_ready_o (mc_ready),
    .push_data_i  ({mc_addr, mc_data}),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  assign {head_addr, head_data} = fifo_head;

  // Writeback has no backpressure, so it always wins the port.
  assign fifo_pop = !wb_valid && !fifo_empty;

  always_comb begin
    reg_we_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    if (wb_valid) begin
      reg_we_d   = 1'b1;
      reg_addr_d = wb_addr;
      reg_data_d = wb_data;
    end else if (fifo_pop) begin
      reg_we_d   = 1'b1;
      reg_addr_d = head_addr;
      reg_data_d = head_data;
    end
  end

  assign hazard     = pending_q[issue_rs1] || pending_q[issue_rs2] || pending_q[issue_rd];
  assign starve     = (starve_cnt_q >= SC_LIMIT);
  assign stall      = (issue_valid && hazard) || fifo_full || starve;
  assign issue_fire = issue_valid && issue_long && !stall;

  // The set is applied last so a same-edge issue to a retiring register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop)   pending_d[head_addr] = 1'b0;
    if (issue_fire) pending_d[issue_rd]  = 1'b1;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_pop || fifo_empty) begin
      starve_cnt_d = '0;
    end else if (wb_valid && (starve_cnt_q != SC_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
      pending_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
      pending_q    <= pending_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign reg_we         = reg_we_q;
  assign reg_write_addr = reg_addr_q;
  assign reg_writedata  = reg_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: table vectors, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              issue_valid, issue_long;
  logic [ADDR_W-1:0] issue_rd, issue_rs1, issue_rs2;
  logic              stall;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              mc_valid, mc_ready;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_write_addr;
  logic [DATA_W-1:0] reg_writedata;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_long     (issue_long),
    .issue_rd       (issue_rd),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .mc_valid       (mc_valid),
    .mc_ready       (mc_ready),
    .mc_addr        (mc_addr),
    .mc_data        (mc_data),
    .reg_we         (reg_we),
    .reg_write_addr (reg_write_addr),
    .reg_writedata  (reg_writedata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffered results as a queue, pending as a bit per register.
  rf_wr_t            m_q[$];
  bit                m_pend[NUM_REGS];
  int                m_cnt;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                mc_hold;

  typedef struct {
    logic              wv;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              ew;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_full();
    return m_q.size() == FIFO_DEPTH;
  endfunction

  function automatic bit m_stall();
    bit hz;
    hz = m_pend[issue_rs1] || m_pend[issue_rs2] || m_pend[issue_rd];
    return (issue_valid && hz) || m_full() || (m_cnt >= STARVE_LIMIT);
  endfunction

  task automatic m_reset();
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_cnt   = 0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    mc_hold = 1'b0;
  endtask

  task automatic m_step();
    bit     full, stl, had, pop;
    rf_wr_t head, e;
    full = m_full();
    stl  = m_stall();
    had  = (m_q.size() != 0);
    pop  = !wb_valid && had;
    if (pop) head = m_q.pop_front();
    if (wb_valid) begin
      m_we = 1'b1; m_addr = wb_addr; m_data = wb_data;
    end else if (pop) begin
      m_we = 1'b1; m_addr = head.addr; m_data = head.data;
    end else begin
      m_we = 1'b0;
    end
    if (mc_valid && !full) begin
      e.addr = mc_addr;
      e.data = mc_data;
      m_q.push_back(e);
    end
    if (pop) m_pend[head.addr] = 1'b0;
    if (issue_valid && issue_long && !stl) m_pend[issue_rd] = 1'b1;
    if (pop || !had) m_cnt = 0;
    else if (wb_valid && m_cnt < STARVE_LIMIT) m_cnt++;
    mc_hold = mc_valid && full;
  endtask

  task automatic cycle();
    #1;
    chk("stall", {63'd0, stall}, {63'd0, m_stall()});
    chk("mc_ready", {63'd0, mc_ready}, {63'd0, !m_full()});
    m_step();
    @(posedge clk);
    #1;
    chk("reg_we", {63'd0, reg_we}, {63'd0, m_we});
    chk("reg_write_addr", 64'(reg_write_addr), 64'(m_addr));
    chk("reg_writedata", 64'(reg_writedata), 64'(m_data));
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_long = 1'b0;
    issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
  endtask

  task automatic rand_inputs();
    issue_valid = 1'($urandom_range(0, 1));
    issue_long  = 1'($urandom_range(0, 1));
    issue_rd    = ADDR_W'($urandom_range(0, NUM_REGS - 1));
    issue_rs1   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
    issue_rs2   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
    wb_valid    = 1'($urandom_range(0, 1));
    wb_addr     = ADDR_W'($urandom_range(0, NUM_REGS - 1));
    wb_data     = $urandom;
    mc_valid    = 1'($urandom_range(0, 1));
    mc_addr     = ADDR_W'($urandom_range(0, NUM_REGS - 1));
    mc_data     = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, {63'd0, reg_we}, 64'd0);
    chk({tag, "_addr"}, 64'(reg_write_addr), 64'd0);
    chk({tag, "_data"}, 64'(reg_writedata), 64'd0);
    chk({tag, "_mc_ready"}, {63'd0, mc_ready}, 64'd1);
    chk({tag, "_stall"}, {63'd0, stall}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 1'b1, 4'd3,  32'hDEADBEEF};
    vt[1] = '{1'b0, 4'd9,  32'h00000001, 1'b0, 4'd3,  32'hDEADBEEF};
    vt[2] = '{1'b1, 4'd15, 32'h00000000, 1'b1, 4'd15, 32'h00000000};
    vt[3] = '{1'b1, 4'd0,  32'hFFFFFFFF, 1'b1, 4'd0,  32'hFFFFFFFF};
    vt[4] = '{1'b0, 4'd7,  32'h5A5A5A5A, 1'b0, 4'd0,  32'hFFFFFFFF};

    // Reset held with inputs toggling.
    idle();
    #2 rst = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rand_inputs();
      #1 check_reset_outputs("rst");
    end
    @(negedge clk);
    idle();
    rst = 1'b1;

    // Writeback pass-through and hold when idle.
    for (int i = 0; i < 5; i++) begin
      wb_valid = vt[i].wv; wb_addr = vt[i].wa; wb_data = vt[i].wd;
      cycle();
      chk("tbl_we", {63'd0, reg_we}, {63'd0, vt[i].ew});
      chk("tbl_addr", 64'(reg_write_addr), 64'(vt[i].ea));
      chk("tbl_data", 64'(reg_writedata), 64'(vt[i].ed));
    end

    // Long-op hazard and two-cycle result latency.
    idle();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 4'd5;
    #1 chk("hz_issue_ok", {63'd0, stall}, 64'd0);
    cycle();
    issue_long = 1'b0; issue_rd = 4'd1; issue_rs1 = 4'd5; issue_rs2 = 4'd2;
    #1 chk("hz_raw_stall", {63'd0, stall}, 64'd1);
    cycle();
    mc_valid = 1'b1; mc_addr = 4'd5; mc_data = 32'h12345678;
    cycle();
    mc_valid = 1'b0;
    chk("hz_latency_we", {63'd0, reg_we}, 64'd0);
    chk("hz_stall_held", {63'd0, stall}, 64'd1);
    cycle();
    chk("hz_we", {63'd0, reg_we}, 64'd1);
    chk("hz_addr", 64'(reg_write_addr), 64'd5);
    chk("hz_data", 64'(reg_writedata), 64'h12345678);
    chk("hz_stall_drop", {63'd0, stall}, 64'd0);

    // Contention: results buffered behind writeback, drained in order.
    idle();
    wb_valid = 1'b1; wb_addr = 4'd1; wb_data = 32'h1111;
    mc_valid = 1'b1; mc_addr = 4'd6; mc_data = 32'hA6;
    cycle();
    mc_addr = 4'd7; mc_data = 32'hA7;
    cycle();
    mc_valid = 1'b0;
    #1 chk("ct_ready_low", {63'd0, mc_ready}, 64'd0);
    chk("ct_full_stall", {63'd0, stall}, 64'd1);
    wb_valid = 1'b0;
    cycle();
    chk("ct_first_addr", 64'(reg_write_addr), 64'd6);
    chk("ct_first_data", 64'(reg_writedata), 64'hA6);
    cycle();
    chk("ct_second_addr", 64'(reg_write_addr), 64'd7);
    chk("ct_second_data", 64'(reg_writedata), 64'hA7);
    cycle();
    chk("ct_drained_we", {63'd0, reg_we}, 64'd0);

    // Starvation: stall after STARVE_LIMIT preempted cycles, held until pop.
    idle();
    wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 32'h2222;
    mc_valid = 1'b1; mc_addr = 4'd8; mc_data = 32'h88;
    cycle();
    mc_valid = 1'b0;
    for (int k = 1; k < STARVE_LIMIT; k++) begin
      cycle();
      chk("sv_no_stall", {63'd0, stall}, 64'd0);
    end
    cycle();
    chk("sv_stall", {63'd0, stall}, 64'd1);
    cycle();
    cycle();
    chk("sv_stall_held", {63'd0, stall}, 64'd1);
    wb_valid = 1'b0;
    cycle();
    chk("sv_pop_addr", 64'(reg_write_addr), 64'd8);
    chk("sv_pop_data", 64'(reg_writedata), 64'h88);
    chk("sv_stall_release", {63'd0, stall}, 64'd0);

    // Asynchronous reset with two buffered results and pending[9].
    idle();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 4'd9;
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'h3333;
    cycle();
    issue_valid = 1'b0;
    mc_valid = 1'b1; mc_addr = 4'd10; mc_data = 32'hAA;
    cycle();
    mc_addr = 4'd11; mc_data = 32'hBB;
    cycle();
    mc_valid = 1'b0;
    #1 chk("ar_full_before", {63'd0, mc_ready}, 64'd0);
    #2 rst = 1'b0;
    m_reset();
    #1 check_reset_outputs("ar");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_inputs();
      #1 check_reset_outputs("ar_hold");
    end
    @(negedge clk);
    idle();
    rst = 1'b1;
    issue_valid = 1'b1; issue_rs1 = 4'd9; issue_rs2 = 4'd9; issue_rd = 4'd0;
    #1 chk("ar_pending_clear", {63'd0, stall}, 64'd0);
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("ar_no_write", {63'd0, reg_we}, 64'd0);
    end

    // Randomized traffic with varying writeback pressure.
    for (int n = 0; n < 600; n++) begin
      int pct;
      case (n / 100)
        0: pct = 20;
        1: pct = 50;
        2: pct = 95;
        3: pct = 70;
        4: pct = 10;
        default: pct = 85;
      endcase
      if (!mc_hold) begin
        mc_valid = ($urandom_range(0, 99) < 45);
        mc_addr  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
        mc_data  = $urandom;
      end
      wb_valid    = ($urandom_range(0, 99) < pct);
      wb_addr     = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      wb_data     = $urandom;
      issue_valid = ($urandom_range(0, 99) < 60);
      issue_long  = ($urandom_range(0, 99) < 30);
      issue_rd    = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      issue_rs1   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      issue_rs2   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
